md_sequencer: RTL

- Multiply/divide sequencer for the EX stage of the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX using forwarded operands, and holds HI/LO.
- Models fixed multi-cycle latency with a busy counter.
- Issues a stall request to the hazard unit so that a D-stage md instruction stalls while the unit is busy.

---
 rtl/md_pkg.sv | 34 +++
 rtl/md_sequencer_if.sv | 25 ++
 rtl/md_calc.sv | 79 +++++++
 rtl/md_sequencer.sv | 131 +++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_sequencer shared definitions: op codes, FSM states, result bundle.
// Default latencies for the EX-stage multiply/divide unit.
package md_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  function automatic logic md_is_long(
    input logic [2:0] op
  );
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// EX-side bundle of md_sequencer: operands and op in, HI/LO,
// busy and stall request out.
interface md_sequencer_if;

  logic        start;
  logic [2:0]  op;
  logic [31:0] rdata_a;
  logic [31:0] rdata_b;
  logic        d_md_use;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rdata_a, rdata_b, d_md_use,
    input  busy, stall_req, hi, lo
  );

  modport slave (
    input  start, op, rdata_a, rdata_b, d_md_use,
    output busy, stall_req, hi, lo
  );

endinterface

// File: rtl/md_calc.sv
// Combinational 64-bit multiply/divide result for md_sequencer,
// including divide-by-zero and INT_MIN/-1 handling.
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output md_res_t     res
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] mag_bd;
  logic [31:0] b_nz;
  logic [31:0] sq_mag;
  logic [31:0] sr_mag;
  logic [31:0] s_quo;
  logic [31:0] s_rem;
  logic [31:0] u_quo;
  logic [31:0] u_rem;
  logic        b_zero;
  logic        ovf;

  assign b_zero = (b == 32'd0);
  assign ovf    = (a == 32'h8000_0000) &&
                  (b == 32'hFFFF_FFFF);

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide on magnitudes; quotient sign from both
  // operands, remainder sign from the dividend.
  assign mag_a  = a[31] ? -a : a;
  assign mag_b  = b[31] ? -b : b;
  assign mag_bd = b_zero ? 32'd1 : mag_b;
  assign b_nz   = b_zero ? 32'd1 : b;

  assign sq_mag = mag_a / mag_bd;
  assign sr_mag = mag_a % mag_bd;
  assign s_quo  = (a[31] ^ b[31]) ? -sq_mag : sq_mag;
  assign s_rem  = a[31] ? -sr_mag : sr_mag;

  assign u_quo = a / b_nz;
  assign u_rem = a % b_nz;

  always_comb begin
    res = '0;
    unique case (op)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV: begin
        if (b_zero) begin
          res.hi = a;
          res.lo = 32'hFFFF_FFFF;
        end else if (ovf) begin
          res.hi = 32'd0;
          res.lo = 32'h8000_0000;
        end else begin
          res.hi = s_rem;
          res.lo = s_quo;
        end
      end
      MD_DIVU: begin
        if (b_zero) begin
          res.hi = a;
          res.lo = 32'hFFFF_FFFF;
        end else begin
          res.hi = u_rem;
          res.lo = u_quo;
        end
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// EX-stage multiply/divide sequencer: HI/LO, busy counter, stall.
// Optional MD_FLUSH_EN adds a flush input that aborts/blocks ops.
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
)(
  input logic           clk,
  input logic           reset,
  md_sequencer_if.slave md
`ifdef MD_FLUSH_EN
  ,
  input logic           flush
`endif
);

  localparam logic [CNT_W-1:0] MULT_LAST =
    CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST =
    CNT_W'(DIV_CYCLES - 1);

  md_state_t        state_q;
  md_state_t        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  md_res_t          pend_q;
  md_res_t          pend_d;
  md_res_t          res;
  logic [31:0]      hi_q;
  logic [31:0]      hi_d;
  logic [31:0]      lo_q;
  logic [31:0]      lo_d;
  logic             kill;
  logic             busy;
  logic             is_mul;
  logic             is_div;
  logic             is_mthi;
  logic             is_mtlo;

`ifdef MD_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  md_calc u_calc (
    .op  (md.op),
    .a   (md.rdata_a),
    .b   (md.rdata_b),
    .res (res)
  );

  assign is_mul  = (md.op == MD_MULT) ||
                   (md.op == MD_MULTU);
  assign is_div  = (md.op == MD_DIV) ||
                   (md.op == MD_DIVU);
  assign is_mthi = (md.op == MD_MTHI);
  assign is_mtlo = (md.op == MD_MTLO);

  assign busy = (state_q == S_BUSY);

  // Includes the issue cycle so a dependent D-stage op never
  // slips past before busy rises.
  assign md.stall_req = md.d_md_use &
    (busy | (md.start & md_is_long(md.op)));
  assign md.busy = busy;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (md.start && !kill) begin
          unique case (1'b1)
            is_mul: begin
              pend_d  = res;
              cnt_d   = MULT_LAST;
              state_d = S_BUSY;
            end
            is_div: begin
              pend_d  = res;
              cnt_d   = DIV_LAST;
              state_d = S_BUSY;
            end
            is_mthi: hi_d = md.rdata_a;
            is_mtlo: lo_d = md.rdata_a;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        if (kill) begin
          pend_d  = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          hi_d    = pend_q.hi;
          lo_d    = pend_q.lo;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule
